// File: rtl/fsk_modulate.sv
// Serial FSK transmitter: sends a 14-bit codeword LSB first. Each bit is a burst of
// 2*WINDOW clocks at carrier period P1 (bit 1) or P0 (bit 0), plus a bit-rate strobe.
`timescale 1ns/1ps
module fsk_modulate #(
  parameter int WINDOW = 48,
  parameter int P1     = 8,
  parameter int P0     = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] Hamcode_in,
  input  logic        start,
  output logic        ready,
  output logic        busy,
  output logic        fsk_signal,
  output logic        clk_bitTransferRate,
  output logic [3:0]  bit_index,
  output logic        frame_done
);

  localparam int CYC_W = $clog2(2 * WINDOW);
  localparam int PMAX  = (P0 > P1) ? P0 : P1;
  localparam int CAR_W = $clog2(PMAX);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(2 * WINDOW - 1);
  localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(WINDOW);
  localparam logic [3:0]       BIT_LAST = 4'd13;
  localparam logic [CAR_W-1:0] P1_LAST  = CAR_W'(P1 - 1);
  localparam logic [CAR_W-1:0] P0_LAST  = CAR_W'(P0 - 1);
  localparam logic [CAR_W-1:0] P1_HALF  = CAR_W'(P1 / 2);
  localparam logic [CAR_W-1:0] P0_HALF  = CAR_W'(P0 / 2);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [13:0]      sreg_q, sreg_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CAR_W-1:0] car_cnt_q, car_cnt_d;

  // Carrier parameters follow the bit currently on the line.
  logic [CAR_W-1:0] car_last;
  logic [CAR_W-1:0] car_half;
  assign car_last = sreg_q[0] ? P1_LAST : P0_LAST;
  assign car_half = sreg_q[0] ? P1_HALF : P0_HALF;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      car_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      car_cnt_q <= car_cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaulting every _d first means no path leaves one unassigned (no latch).
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    car_cnt_d = car_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SEND;
          sreg_d    = Hamcode_in;
          bit_cnt_d = '0;
          cyc_cnt_d = '0;
          car_cnt_d = '0;
        end
      end
      SEND: begin
        if (cyc_cnt_q == CYC_LAST) begin
          // Bit boundary: next bit starts with a fresh carrier cycle.
          cyc_cnt_d = '0;
          car_cnt_d = '0;
          sreg_d    = {1'b0, sreg_q[13:1]};
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
          car_cnt_d = (car_cnt_q == car_last) ? '0 : car_cnt_q + CAR_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    busy                = (state_q == SEND);
    ready               = !busy;
    fsk_signal          = busy && (car_cnt_q < car_half);
    clk_bitTransferRate = busy && (cyc_cnt_q < CYC_HALF);
    bit_index           = bit_cnt_q;
    frame_done          = busy && (cyc_cnt_q == CYC_LAST) && (bit_cnt_q == BIT_LAST);
  end

endmodule
